// File: rtl/shift_arbiter_pkg.sv
// Shared ALU package for the shift arbiter.
// Holds the shifter data/shift-amount widths and the arbiter FSM state encoding.
package shift_arbiter_pkg;
    localparam int DW = 16;  // data width, tied to the shared shifter
    localparam int SW = 4;   // shift-amount width, log2(DW)

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_OWN0 = 2'd1;
    localparam logic [1:0] ARB_OWN1 = 2'd2;
endpackage

// File: rtl/shift_arbiter_if.sv
// Client-side bus of the shift arbiter.
//   req0/in0/shamt0/lock0 : client 0 request, operand, shift amount, lock
//   req1/in1/shamt1/lock1 : client 1, same meaning
//   ack0/ack1             : one-cycle completion pulses
//   out                   : registered result, valid while an ack is high
//   busy                  : arbiter currently owned by one client
// master = client side, slave = arbiter side.
interface shift_arbiter_if;
    import shift_arbiter_pkg::*;

    logic          req0;
    logic [DW-1:0] in0;
    logic [SW-1:0] shamt0;
    logic          lock0;
    logic          req1;
    logic [DW-1:0] in1;
    logic [SW-1:0] shamt1;
    logic          lock1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] out;
    logic          busy;

    modport master (
        output req0, in0, shamt0, lock0, req1, in1, shamt1, lock1,
        input  ack0, ack1, out, busy
    );

    modport slave (
        input  req0, in0, shamt0, lock0, req1, in1, shamt1, lock1,
        output ack0, ack1, out, busy
    );
endinterface

// File: rtl/shift_arbiter_arithshift.sv
// Combinational arithmetic right shifter (sign-filled).
//   din   : operand
//   shamt : shift amount 0..DW-1
//   dout  : din >>> shamt
module shift_arbiter_arithshift
    import shift_arbiter_pkg::*;
(
    input  logic [DW-1:0] din,
    input  logic [SW-1:0] shamt,
    output logic [DW-1:0] dout
);
    assign dout = $unsigned($signed(din) >>> shamt);
endmodule

// File: rtl/shift_arbiter.sv
// Two-client arbiter in front of one shared arithmetic right shifter.
// Round-robin between clients, with an optional lock that lets the granted
// client keep ownership for a burst. Result is registered and returned with
// a one-cycle ack.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : client bus (slave modport), see shift_arbiter_if
module shift_arbiter
    import shift_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    shift_arbiter_if.slave  bus
);
    logic [1:0]    state, state_nx;
    logic          rr_ptr, rr_nx;
    logic          ack0_q, ack1_q;
    logic [DW-1:0] out_q;
    logic          elig0, elig1;
    logic          gnt0, gnt1;
    logic [DW-1:0] sh_in, sh_res;
    logic [SW-1:0] sh_amt;

    // A client that is being acked this cycle still has req high while it
    // reacts; masking it here keeps the old request from being granted twice.
    assign elig0 = bus.req0 & ~ack0_q;
    assign elig1 = bus.req1 & ~ack1_q;

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        state_nx = state;
        rr_nx    = rr_ptr;
        case (state)
            ARB_IDLE: begin
                if (elig0 && elig1) begin
                    gnt0  = ~rr_ptr;
                    gnt1  = rr_ptr;
                    rr_nx = ~rr_ptr;
                end else begin
                    gnt0 = elig0;
                    gnt1 = elig1;
                end
                // only the granted client's lock matters
                if (gnt0 && bus.lock0)
                    state_nx = ARB_OWN0;
                else if (gnt1 && bus.lock1)
                    state_nx = ARB_OWN1;
            end
            ARB_OWN0: begin
                gnt0 = elig0;
                if (!bus.lock0) begin
                    state_nx = ARB_IDLE;
                    rr_nx    = 1'b1;
                end
            end
            ARB_OWN1: begin
                gnt1 = elig1;
                if (!bus.lock1) begin
                    state_nx = ARB_IDLE;
                    rr_nx    = 1'b0;
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    // Operand mux follows the grant; at most one grant is ever high.
    assign sh_in  = gnt1 ? bus.in1    : bus.in0;
    assign sh_amt = gnt1 ? bus.shamt1 : bus.shamt0;

    shift_arbiter_arithshift u_shift (
        .din   (sh_in),
        .shamt (sh_amt),
        .dout  (sh_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            rr_ptr <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            out_q  <= '0;
        end else begin
            state  <= state_nx;
            rr_ptr <= rr_nx;
            ack0_q <= gnt0;
            ack1_q <= gnt1;
            if (gnt0 || gnt1)
                out_q <= sh_res;
        end
    end

    assign bus.ack0 = ack0_q;
    assign bus.ack1 = ack1_q;
    assign bus.out  = out_q;
    assign bus.busy = (state != ARB_IDLE);
endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_arbiter_if bus();

    shift_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          c;
        logic [15:0] d;
        logic [3:0]  sh;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    // one clock, then sample 1 time unit after the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.in0 = '0; bus.shamt0 = '0; bus.lock0 = 1'b0;
        bus.req1 = 1'b0; bus.in1 = '0; bus.shamt1 = '0; bus.lock1 = 1'b0;
    endtask

    // called 1 unit after an edge; pulse stays well clear of the next edge
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // independent shift model: shift one bit at a time, replicating the sign
    function automatic logic [15:0] ref_asr(input logic [15:0] d, input logic [3:0] sh);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < int'(sh); i++)
            r = {r[15], r[15:1]};
        return r;
    endfunction

    task automatic single_op(input string nm, input bit c, input logic [15:0] d,
                             input logic [3:0] sh, input logic [15:0] exp);
        if (!c) begin bus.req0 = 1'b1; bus.in0 = d; bus.shamt0 = sh; end
        else    begin bus.req1 = 1'b1; bus.in1 = d; bus.shamt1 = sh; end
        step();
        chk1({nm, " ack"},   c ? bus.ack1 : bus.ack0, 1'b1);
        chk1({nm, " other"}, c ? bus.ack0 : bus.ack1, 1'b0);
        chk16({nm, " out"},  bus.out, exp);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        chk1({nm, " dup"}, bus.ack0 | bus.ack1, 1'b0);
        chk16({nm, " hold"}, bus.out, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'hF0F0, 4'd4,  16'hFF0F};
        vecs[1]  = '{1'b0, 16'h7F00, 4'd8,  16'h007F};
        vecs[2]  = '{1'b0, 16'h1234, 4'd0,  16'h1234};
        vecs[3]  = '{1'b0, 16'h8000, 4'd15, 16'hFFFF};
        vecs[4]  = '{1'b0, 16'h7FFF, 4'd15, 16'h0000};
        vecs[5]  = '{1'b1, 16'h8000, 4'd4,  16'hF800};
        vecs[6]  = '{1'b1, 16'h4000, 4'd2,  16'h1000};
        vecs[7]  = '{1'b1, 16'h8001, 4'd1,  16'hC000};
        vecs[8]  = '{1'b1, 16'hABCD, 4'd0,  16'hABCD};
        vecs[9]  = '{1'b1, 16'hFFFF, 4'd7,  16'hFFFF};
        vecs[10] = '{1'b1, 16'h5A5A, 4'd3,  16'h0B4B};
        vecs[11] = '{1'b1, 16'h8000, 4'd15, 16'hFFFF};

        idle_inputs();

        // ---- reset state
        #12;
        chk1("rst ack0", bus.ack0, 1'b0);
        chk1("rst ack1", bus.ack1, 1'b0);
        chk16("rst out", bus.out, 16'h0000);
        chk1("rst busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        step();

        // ---- reset mid-op: request lands, reset hits before its edge
        bus.req0 = 1'b1; bus.in0 = 16'h8000; bus.shamt0 = 4'd4;
        #3;
        rst_n = 1'b0;
        step();
        chk1("midrst ack0", bus.ack0, 1'b0);
        chk16("midrst out", bus.out, 16'h0000);
        chk1("midrst busy", bus.busy, 1'b0);
        bus.req1 = 1'b1; bus.in1 = 16'h0F00; bus.shamt1 = 4'd8;
        rst_n = 1'b1;
        step();
        chk1("postrst ack0", bus.ack0, 1'b1);
        chk1("postrst ack1", bus.ack1, 1'b0);
        chk16("postrst out0", bus.out, 16'hF800);
        bus.req0 = 1'b0;
        step();
        chk1("postrst ack1 next", bus.ack1, 1'b1);
        chk16("postrst out1", bus.out, 16'h000F);
        bus.req1 = 1'b0;
        step();
        chk1("postrst quiet", bus.ack0 | bus.ack1, 1'b0);

        // ---- directed single-op table
        foreach (vecs[i])
            single_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].d, vecs[i].sh, vecs[i].exp);

        // ---- contention: both held, acks alternate starting with client 0
        do_reset();
        bus.req0 = 1'b1; bus.in0 = 16'h8001; bus.shamt0 = 4'd1;
        bus.req1 = 1'b1; bus.in1 = 16'h4000; bus.shamt1 = 4'd2;
        for (int i = 0; i < 6; i++) begin
            step();
            chk1($sformatf("cont%0d ack0", i), bus.ack0, (i % 2) == 0);
            chk1($sformatf("cont%0d ack1", i), bus.ack1, (i % 2) != 0);
            chk16($sformatf("cont%0d out", i), bus.out, (i % 2 == 0) ? 16'hC000 : 16'h1000);
            if (i == 5) bus.req1 = 1'b0;
        end
        step();
        chk1("cont tail ack0", bus.ack0, 1'b1);
        chk1("cont tail ack1", bus.ack1, 1'b0);
        bus.req0 = 1'b0;
        step();
        chk1("cont quiet", bus.ack0 | bus.ack1, 1'b0);

        // ---- lock burst: client 0 owns for 3 ops, client 1 stalled
        do_reset();
        bus.req0 = 1'b1; bus.in0 = 16'h8000; bus.shamt0 = 4'd1; bus.lock0 = 1'b1;
        bus.req1 = 1'b1; bus.in1 = 16'h00FF; bus.shamt1 = 4'd4;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1($sformatf("lock%0d ack0", i), bus.ack0, (i % 2) == 0);
            chk1($sformatf("lock%0d ack1", i), bus.ack1, 1'b0);
            chk1($sformatf("lock%0d busy", i), bus.busy, 1'b1);
        end
        chk16("lock out", bus.out, 16'hC000);
        bus.req0 = 1'b0; bus.lock0 = 1'b0;
        step();
        chk1("unlock busy", bus.busy, 1'b0);
        chk1("unlock ack1 early", bus.ack1, 1'b0);
        step();
        chk1("unlock ack1", bus.ack1, 1'b1);
        chk16("unlock out", bus.out, 16'h000F);
        bus.req1 = 1'b0;
        step();

        // ---- both locks in one IDLE cycle: only the winner owns
        do_reset();
        bus.req0 = 1'b1; bus.in0 = 16'h0010; bus.shamt0 = 4'd4; bus.lock0 = 1'b1;
        bus.req1 = 1'b1; bus.in1 = 16'hFF00; bus.shamt1 = 4'd4; bus.lock1 = 1'b1;
        step();
        chk1("dlock ack0", bus.ack0, 1'b1);
        chk1("dlock ack1", bus.ack1, 1'b0);
        chk1("dlock busy", bus.busy, 1'b1);
        chk16("dlock out0", bus.out, 16'h0001);
        bus.req0 = 1'b0; bus.lock0 = 1'b0;
        step();
        chk1("dlock exit busy", bus.busy, 1'b0);
        chk1("dlock exit ack", bus.ack0 | bus.ack1, 1'b0);
        step();
        chk1("dlock ack1 late", bus.ack1, 1'b1);
        chk1("dlock own1 busy", bus.busy, 1'b1);
        chk16("dlock out1", bus.out, 16'hFFF0);
        bus.req1 = 1'b0; bus.lock1 = 1'b0;
        step();
        chk1("dlock final busy", bus.busy, 1'b0);

        // ---- back-to-back single client: one ack every other cycle
        bus.req0 = 1'b1; bus.in0 = 16'h1234; bus.shamt0 = 4'd2;
        for (int i = 0; i < 8; i++) begin
            step();
            chk1($sformatf("b2b%0d ack0", i), bus.ack0, (i % 2) == 0);
            chk1($sformatf("b2b%0d ack1", i), bus.ack1, 1'b0);
            if (i == 6) bus.req0 = 1'b0;
        end
        chk16("b2b out", bus.out, 16'h048D);

        // ---- sweep all shift amounts on both clients against the model
        for (int sh = 0; sh < 16; sh++) begin
            for (int c = 0; c < 2; c++) begin
                logic [15:0] d;
                d = 16'($urandom);
                single_op($sformatf("sweep c%0d sh%0d", c, sh), c[0], d, 4'(sh),
                          ref_asr(d, 4'(sh)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
